// File: rtl/tl_ul_link_pkg.sv
// Shared beat types and field widths for the TL-UL link buffer.
package tl_ul_link_pkg;

  localparam int TL_AW = 30;
  localparam int TL_SW = 7;
  localparam int TL_DW = 32;
  localparam int TL_MW = 4;
  localparam int TL_ZW = 2;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [2:0]       param;
    logic [TL_ZW-1:0] size;
    logic [TL_SW-1:0] source;
    logic [TL_AW-1:0] address;
    logic [TL_MW-1:0] mask;
    logic [TL_DW-1:0] data;
  } tl_a_beat_t;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [1:0]       param;
    logic [TL_ZW-1:0] size;
    logic [TL_SW-1:0] source;
    logic             sink;
    logic             denied;
    logic [TL_DW-1:0] data;
    logic             corrupt;
  } tl_d_beat_t;

endpackage

// File: rtl/tl_ul_fifo.sv
// Registered valid/ready FIFO; full/empty come from an explicit count so DEPTH
// need not be a power of two. Neither flow-through nor pipe.
module tl_ul_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid,
  output logic o_ready,
  input  T     i_data,
  output logic o_valid,
  input  logic i_ready,
  output T     o_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_ready = (r_count != CW'(DEPTH));
  assign o_valid = (r_count != '0);
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;
  assign o_data  = r_mem[r_rd_ptr];

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tl_ul_link_buffer.sv
// TL-UL link buffer: A and D channel FIFOs, outstanding-request cap and a
// sticky flag for D responses arriving with nothing outstanding.
module tl_ul_link_buffer
  import tl_ul_link_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              in_a_valid,
  output logic                              in_a_ready,
  input  logic [2:0]                        in_a_opcode,
  input  logic [2:0]                        in_a_param,
  input  logic [TL_ZW-1:0]                  in_a_size,
  input  logic [TL_SW-1:0]                  in_a_source,
  input  logic [TL_AW-1:0]                  in_a_address,
  input  logic [TL_MW-1:0]                  in_a_mask,
  input  logic [TL_DW-1:0]                  in_a_data,
  output logic                              out_a_valid,
  input  logic                              out_a_ready,
  output logic [2:0]                        out_a_opcode,
  output logic [2:0]                        out_a_param,
  output logic [TL_ZW-1:0]                  out_a_size,
  output logic [TL_SW-1:0]                  out_a_source,
  output logic [TL_AW-1:0]                  out_a_address,
  output logic [TL_MW-1:0]                  out_a_mask,
  output logic [TL_DW-1:0]                  out_a_data,
  input  logic                              in_d_valid,
  output logic                              in_d_ready,
  input  logic [2:0]                        in_d_opcode,
  input  logic [1:0]                        in_d_param,
  input  logic [TL_ZW-1:0]                  in_d_size,
  input  logic [TL_SW-1:0]                  in_d_source,
  input  logic                              in_d_sink,
  input  logic                              in_d_denied,
  input  logic [TL_DW-1:0]                  in_d_data,
  input  logic                              in_d_corrupt,
  output logic                              out_d_valid,
  input  logic                              out_d_ready,
  output logic [2:0]                        out_d_opcode,
  output logic [1:0]                        out_d_param,
  output logic [TL_ZW-1:0]                  out_d_size,
  output logic [TL_SW-1:0]                  out_d_source,
  output logic                              out_d_sink,
  output logic                              out_d_denied,
  output logic [TL_DW-1:0]                  out_d_data,
  output logic                              out_d_corrupt,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              err_d_underflow
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  tl_a_beat_t    w_a_in;
  tl_a_beat_t    w_a_out;
  tl_d_beat_t    w_d_in;
  tl_d_beat_t    w_d_out;
  logic          w_a_nonempty;
  logic          w_a_gate;
  logic          w_a_fire;
  logic          w_d_enq;
  logic [IW-1:0] r_inflight;
  logic          r_err_d_underflow;

  assign w_a_in = '{opcode: in_a_opcode, param: in_a_param, size: in_a_size,
                    source: in_a_source, address: in_a_address, mask: in_a_mask,
                    data: in_a_data};
  assign w_d_in = '{opcode: in_d_opcode, param: in_d_param, size: in_d_size,
                    source: in_d_source, sink: in_d_sink, denied: in_d_denied,
                    data: in_d_data, corrupt: in_d_corrupt};

  // Gate on the registered count only, so a same-cycle D cannot reopen it.
  assign w_a_gate    = (r_inflight < IW'(MAX_INFLIGHT));
  assign out_a_valid = w_a_nonempty & w_a_gate;
  assign w_a_fire    = out_a_valid & out_a_ready;
  assign w_d_enq     = in_d_valid & in_d_ready;

  tl_ul_fifo #(.T(tl_a_beat_t), .DEPTH(DEPTH)) u_a_fifo (
    .clk     (clock),
    .rst_n   (reset_n),
    .i_valid (in_a_valid),
    .o_ready (in_a_ready),
    .i_data  (w_a_in),
    .o_valid (w_a_nonempty),
    .i_ready (out_a_ready & w_a_gate),
    .o_data  (w_a_out)
  );

  tl_ul_fifo #(.T(tl_d_beat_t), .DEPTH(DEPTH)) u_d_fifo (
    .clk     (clock),
    .rst_n   (reset_n),
    .i_valid (in_d_valid),
    .o_ready (in_d_ready),
    .i_data  (w_d_in),
    .o_valid (out_d_valid),
    .i_ready (out_d_ready),
    .o_data  (w_d_out)
  );

  assign {out_a_opcode, out_a_param, out_a_size, out_a_source,
          out_a_address, out_a_mask, out_a_data} = w_a_out;
  assign {out_d_opcode, out_d_param, out_d_size, out_d_source,
          out_d_sink, out_d_denied, out_d_data, out_d_corrupt} = w_d_out;

  // One response retires one request; a response with none outstanding is flagged.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight        <= '0;
      r_err_d_underflow <= 1'b0;
    end else begin
      case ({w_a_fire, w_d_enq})
        2'b10: r_inflight <= r_inflight + IW'(1);
        2'b01: begin
          if (r_inflight == '0) begin
            r_err_d_underflow <= 1'b1;
          end else begin
            r_inflight <= r_inflight - IW'(1);
          end
        end
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign inflight        = r_inflight;
  assign err_d_underflow = r_err_d_underflow;

endmodule
